// File: rtl/tvip_axi_read_arbiter.sv
// tvip_axi_read_arbiter
// Round-robin arbiter sharing one downstream AXI read port (AR + R) between
// N_MASTERS upstream read masters. Granted requests are tagged by prepending
// the requester index to the ID; R beats are routed back by that tag.
// Each master is throttled by a per-master outstanding-burst counter.
//
// AR FSM states
//   state | meaning
//   IDLE  | arbitrate among eligible masters, accept winner combinationally
//   SEND  | registered request presented downstream, wait for m_arready
module tvip_axi_read_arbiter #(
  parameter int N_MASTERS       = 2,
  parameter int ID_WIDTH        = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int IDX_W           = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                            aclk,
  input  logic                            areset_n,

  input  logic [N_MASTERS-1:0]            s_arvalid,
  output logic [N_MASTERS-1:0]            s_arready,
  input  logic [N_MASTERS*ID_WIDTH-1:0]   s_arid,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0] s_araddr,
  input  logic [N_MASTERS*8-1:0]          s_arlen,
  input  logic [N_MASTERS*3-1:0]          s_arsize,
  input  logic [N_MASTERS*2-1:0]          s_arburst,

  output logic [N_MASTERS-1:0]            s_rvalid,
  input  logic [N_MASTERS-1:0]            s_rready,
  output logic [ID_WIDTH-1:0]             s_rid,
  output logic [DATA_WIDTH-1:0]           s_rdata,
  output logic [1:0]                      s_rresp,
  output logic                            s_rlast,

  output logic                            m_arvalid,
  input  logic                            m_arready,
  output logic [IDX_W+ID_WIDTH-1:0]       m_arid,
  output logic [ADDR_WIDTH-1:0]           m_araddr,
  output logic [7:0]                      m_arlen,
  output logic [2:0]                      m_arsize,
  output logic [1:0]                      m_arburst,

  input  logic                            m_rvalid,
  output logic                            m_rready,
  input  logic [IDX_W+ID_WIDTH-1:0]       m_rid,
  input  logic [DATA_WIDTH-1:0]           m_rdata,
  input  logic [1:0]                      m_rresp,
  input  logic                            m_rlast
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]                state_q, state_d;
  logic [IDX_W-1:0]          last_grant_q, last_grant_d;
  logic [IDX_W+ID_WIDTH-1:0] m_arid_q, m_arid_d;
  logic [ADDR_WIDTH-1:0]     m_araddr_q, m_araddr_d;
  logic [7:0]                m_arlen_q, m_arlen_d;
  logic [2:0]                m_arsize_q, m_arsize_d;
  logic [1:0]                m_arburst_q, m_arburst_d;
  logic [CNT_W-1:0]          cnt_q [N_MASTERS];
  logic [CNT_W-1:0]          cnt_d [N_MASTERS];

  logic [N_MASTERS-1:0]      eligible;
  logic                      found;
  logic [IDX_W-1:0]          winner;
  logic                      grant;
  logic [IDX_W-1:0]          r_idx;
  logic [N_MASTERS-1:0]      r_done;

  // Eligibility: requesting and below the outstanding limit.
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      eligible[i] = s_arvalid[i] && (cnt_q[i] < CNT_MAX);
    end
  end

  // Round-robin search starting one past the last grant.
  always_comb begin
    int cand;
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      cand = (int'(last_grant_q) + k) % N_MASTERS;
      if (!found && eligible[cand[IDX_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[IDX_W-1:0];
      end
    end
  end

  // Upstream accept is only possible in IDLE and never while reset is held.
  always_comb begin
    grant     = areset_n && (state_q == ST_IDLE) && found;
    s_arready = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (grant && (int'(winner) == i)) s_arready[i] = 1'b1;
    end
  end

  // AR FSM and output field capture.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    m_arid_d     = m_arid_q;
    m_araddr_d   = m_araddr_q;
    m_arlen_d    = m_arlen_q;
    m_arsize_d   = m_arsize_q;
    m_arburst_d  = m_arburst_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d      = ST_SEND;
          last_grant_d = winner;
          m_arid_d     = {winner, s_arid[int'(winner)*ID_WIDTH +: ID_WIDTH]};
          m_araddr_d   = s_araddr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
          m_arlen_d    = s_arlen[int'(winner)*8 +: 8];
          m_arsize_d   = s_arsize[int'(winner)*3 +: 3];
          m_arburst_d  = s_arburst[int'(winner)*2 +: 2];
        end
      end
      ST_SEND: begin
        if (m_arready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // R routing by the index tag; beats carrying an unknown index are sunk.
  always_comb begin
    r_idx    = m_rid[IDX_W+ID_WIDTH-1:ID_WIDTH];
    s_rvalid = '0;
    m_rready = 1'b1;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (int'(r_idx) == i) begin
        s_rvalid[i] = m_rvalid;
        m_rready    = s_rready[i];
      end
    end
    r_done = s_rvalid & s_rready & {N_MASTERS{m_rlast}};
  end

  // Outstanding counters: +1 on grant, -1 on last beat, saturating at 0.
  always_comb begin
    for (int i = 0; i < N_MASTERS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s_arready[i] && !r_done[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (!s_arready[i] && r_done[i] && (cnt_q[i] != '0)) begin
        cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IDX_W'(N_MASTERS - 1);
      m_arid_q     <= '0;
      m_araddr_q   <= '0;
      m_arlen_q    <= '0;
      m_arsize_q   <= '0;
      m_arburst_q  <= '0;
      for (int i = 0; i < N_MASTERS; i++) cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      m_arid_q     <= m_arid_d;
      m_araddr_q   <= m_araddr_d;
      m_arlen_q    <= m_arlen_d;
      m_arsize_q   <= m_arsize_d;
      m_arburst_q  <= m_arburst_d;
      for (int i = 0; i < N_MASTERS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign m_arvalid = (state_q == ST_SEND);
  assign m_arid    = m_arid_q;
  assign m_araddr  = m_araddr_q;
  assign m_arlen   = m_arlen_q;
  assign m_arsize  = m_arsize_q;
  assign m_arburst = m_arburst_q;

  assign s_rid   = m_rid[ID_WIDTH-1:0];
  assign s_rdata = m_rdata;
  assign s_rresp = m_rresp;
  assign s_rlast = m_rlast;

endmodule

// File: tb/tb_tvip_axi_read_arbiter.sv
// Testbench for tvip_axi_read_arbiter: directed AR/R scenarios with an
// expected-request queue checked by an independent downstream AR monitor.
module tb_tvip_axi_read_arbiter;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  int checks   = 0;
  int failures = 0;
  ar_t exp_q[$];

  logic        aclk = 1'b0;
  logic        areset_n;

  // Main DUT: 2 masters, 2 outstanding bursts each.
  logic [1:0]  s_arvalid, s_arready;
  logic [7:0]  s_arid;
  logic [63:0] s_araddr;
  logic [15:0] s_arlen;
  logic [5:0]  s_arsize;
  logic [3:0]  s_arburst;
  logic [1:0]  s_rvalid, s_rready;
  logic [3:0]  s_rid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        m_arvalid, m_arready;
  logic [4:0]  m_arid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rvalid, m_rready;
  logic [4:0]  m_rid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;

  // Second DUT: 3 masters, used for the out-of-range R index case.
  logic [2:0]  s3_arvalid, s3_arready;
  logic [11:0] s3_arid;
  logic [95:0] s3_araddr;
  logic [23:0] s3_arlen;
  logic [8:0]  s3_arsize;
  logic [5:0]  s3_arburst;
  logic [2:0]  s3_rvalid, s3_rready;
  logic [3:0]  s3_rid;
  logic [31:0] s3_rdata;
  logic [1:0]  s3_rresp;
  logic        s3_rlast;
  logic        m3_arvalid, m3_arready;
  logic [5:0]  m3_arid;
  logic [31:0] m3_araddr;
  logic [7:0]  m3_arlen;
  logic [2:0]  m3_arsize;
  logic [1:0]  m3_arburst;
  logic        m3_rvalid, m3_rready;
  logic [5:0]  m3_rid;
  logic [31:0] m3_rdata;
  logic [1:0]  m3_rresp;
  logic        m3_rlast;

  tvip_axi_read_arbiter #(
    .N_MASTERS(2), .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)
  ) dut (
    .aclk(aclk), .areset_n(areset_n),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid), .m_araddr(m_araddr),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast)
  );

  tvip_axi_read_arbiter #(
    .N_MASTERS(3), .ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)
  ) dut3 (
    .aclk(aclk), .areset_n(areset_n),
    .s_arvalid(s3_arvalid), .s_arready(s3_arready), .s_arid(s3_arid), .s_araddr(s3_araddr),
    .s_arlen(s3_arlen), .s_arsize(s3_arsize), .s_arburst(s3_arburst),
    .s_rvalid(s3_rvalid), .s_rready(s3_rready), .s_rid(s3_rid), .s_rdata(s3_rdata),
    .s_rresp(s3_rresp), .s_rlast(s3_rlast),
    .m_arvalid(m3_arvalid), .m_arready(m3_arready), .m_arid(m3_arid), .m_araddr(m3_araddr),
    .m_arlen(m3_arlen), .m_arsize(m3_arsize), .m_arburst(m3_arburst),
    .m_rvalid(m3_rvalid), .m_rready(m3_rready), .m_rid(m3_rid), .m_rdata(m3_rdata),
    .m_rresp(m3_rresp), .m_rlast(m3_rlast)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    areset_n = 1'b0;
    cyc();
    areset_n = 1'b1;
  endtask

  task automatic set_ar(input int i, input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len);
    s_arid[i*4 +: 4]    = id;
    s_araddr[i*32 +: 32] = addr;
    s_arlen[i*8 +: 8]   = len;
  endtask

  task automatic push(input logic [4:0] id, input logic [31:0] addr, input logic [7:0] len);
    ar_t e;
    e.id   = id;
    e.addr = addr;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  // Downstream AR monitor: every completed handshake must match the next expected request.
  always @(negedge aclk) begin
    if (areset_n && m_arvalid && m_arready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ar_unexpected: got id 0x%0h addr 0x%0h, expected no request", m_arid, m_araddr);
      end else begin
        ar_t e;
        e = exp_q.pop_front();
        chk("ar_id", 64'(m_arid), 64'(e.id));
        chk("ar_addr", 64'(m_araddr), 64'(e.addr));
        chk("ar_len", 64'(m_arlen), 64'(e.len));
        chk("ar_size", 64'(m_arsize), 64'd2);
        chk("ar_burst", 64'(m_arburst), 64'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  logic [1:0] rr_rdy [10] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
  logic       rr_vld [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [1:0] lim_rdy [6] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
  logic       lim_vld [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    int wait_cnt;
    areset_n  = 1'b0;
    s_arvalid = '0; s_arid = '0; s_araddr = '0; s_arlen = '0;
    s_arsize  = 6'b010_010; s_arburst = 4'b01_01;
    s_rready  = 2'b11;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0;
    s3_arvalid = '0; s3_arid = '0; s3_araddr = '0; s3_arlen = '0; s3_arsize = '0; s3_arburst = '0;
    s3_rready = '0; m3_arready = 1'b0; m3_rvalid = 1'b0; m3_rid = '0; m3_rdata = '0;
    m3_rresp = '0; m3_rlast = 1'b0;

    // Reset state, with a request pending to show s_arready is forced low.
    repeat (2) cyc();
    s_arvalid = 2'b01;
    @(negedge aclk);
    chk("rst_arready", 64'(s_arready), 64'd0);
    chk("rst_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_arid", 64'(m_arid), 64'd0);
    chk("rst_araddr", 64'(m_araddr), 64'd0);
    chk("rst_arlen", 64'(m_arlen), 64'd0);
    cyc();
    s_arvalid = '0;
    areset_n  = 1'b1;

    // Single request from master 0.
    cyc();
    set_ar(0, 4'd3, 32'h1000, 8'd0);
    s_arvalid = 2'b01;
    @(negedge aclk);
    chk("single_arready", 64'(s_arready), 64'b01);
    push({1'b0, 4'd3}, 32'h1000, 8'd0);
    cyc();
    s_arvalid = '0;
    @(negedge aclk);
    chk("single_arvalid", 64'(m_arvalid), 64'd1);
    chk("single_arready_send", 64'(s_arready), 64'd0);
    cyc();
    m_arready = 1'b1;
    cyc();
    m_arready = 1'b0;

    // Round robin with both masters requesting continuously.
    do_reset();
    set_ar(0, 4'd1, 32'h00A0, 8'd1);
    set_ar(1, 4'd2, 32'h00B0, 8'd2);
    push({1'b0, 4'd1}, 32'h00A0, 8'd1);
    push({1'b1, 4'd2}, 32'h00B0, 8'd2);
    push({1'b0, 4'd1}, 32'h00A0, 8'd1);
    push({1'b1, 4'd2}, 32'h00B0, 8'd2);
    s_arvalid = 2'b11;
    m_arready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge aclk);
      chk($sformatf("rr_arready_%0d", k), 64'(s_arready), 64'(rr_rdy[k]));
      chk($sformatf("rr_arvalid_%0d", k), 64'(m_arvalid), 64'(rr_vld[k]));
      cyc();
    end
    s_arvalid = '0;
    m_arready = 1'b0;

    // Downstream backpressure for five cycles.
    do_reset();
    set_ar(1, 4'd7, 32'h2000, 8'd3);
    s_arvalid = 2'b10;
    @(negedge aclk);
    chk("bp_grant", 64'(s_arready), 64'b10);
    push({1'b1, 4'd7}, 32'h2000, 8'd3);
    cyc();
    set_ar(0, 4'd4, 32'h3000, 8'd0);
    s_arvalid = 2'b01;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      chk($sformatf("bp_arvalid_%0d", k), 64'(m_arvalid), 64'd1);
      chk($sformatf("bp_arready_%0d", k), 64'(s_arready), 64'd0);
      chk($sformatf("bp_arid_%0d", k), 64'(m_arid), 64'h17);
      chk($sformatf("bp_araddr_%0d", k), 64'(m_araddr), 64'h2000);
      chk($sformatf("bp_arlen_%0d", k), 64'(m_arlen), 64'd3);
      cyc();
    end
    m_arready = 1'b1;
    push({1'b0, 4'd4}, 32'h3000, 8'd0);
    @(negedge aclk);
    chk("bp_arready_6th", 64'(s_arready), 64'd0);
    cyc();
    @(negedge aclk);
    chk("bp_next_grant", 64'(s_arready), 64'b01);
    cyc();
    s_arvalid = '0;
    cyc();
    m_arready = 1'b0;

    // Outstanding limit of 2 for master 1, released by a last R beat.
    do_reset();
    set_ar(1, 4'd1, 32'h4000, 8'd0);
    s_arvalid = 2'b10;
    m_arready = 1'b1;
    push({1'b1, 4'd1}, 32'h4000, 8'd0);
    push({1'b1, 4'd1}, 32'h4000, 8'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge aclk);
      chk($sformatf("lim_arready_%0d", k), 64'(s_arready), 64'(lim_rdy[k]));
      chk($sformatf("lim_arvalid_%0d", k), 64'(m_arvalid), 64'(lim_vld[k]));
      cyc();
    end
    m_rvalid = 1'b1;
    m_rid    = {1'b1, 4'd1};
    m_rlast  = 1'b1;
    s_rready = 2'b10;
    @(negedge aclk);
    chk("lim_rvalid", 64'(s_rvalid), 64'b10);
    chk("lim_rready", 64'(m_rready), 64'd1);
    chk("lim_still_blocked", 64'(s_arready), 64'd0);
    push({1'b1, 4'd1}, 32'h4000, 8'd0);
    cyc();
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    @(negedge aclk);
    chk("lim_third_grant", 64'(s_arready), 64'b10);
    cyc();
    s_arvalid = '0;
    cyc();
    m_arready = 1'b0;

    // R routing with upstream backpressure, then a ready master.
    m_rvalid = 1'b1;
    m_rid    = {1'b1, 4'd5};
    m_rdata  = 32'hCAFE_0001;
    m_rresp  = 2'd2;
    s_rready = 2'b01;
    @(negedge aclk);
    chk("r_bp_rvalid", 64'(s_rvalid), 64'b10);
    chk("r_bp_rready", 64'(m_rready), 64'd0);
    chk("r_bp_rid", 64'(s_rid), 64'd5);
    chk("r_bp_rdata", 64'(s_rdata), 64'hCAFE_0001);
    chk("r_bp_rresp", 64'(s_rresp), 64'd2);
    cyc();
    m_rid = {1'b0, 4'd9};
    @(negedge aclk);
    chk("r_m0_rvalid", 64'(s_rvalid), 64'b01);
    chk("r_m0_rready", 64'(m_rready), 64'd1);
    chk("r_m0_rid", 64'(s_rid), 64'd9);
    cyc();
    m_rvalid = 1'b0;
    @(negedge aclk);
    chk("r_idle_rvalid", 64'(s_rvalid), 64'd0);

    // Out-of-range index on the 3-master instance is dropped.
    m3_rvalid = 1'b1;
    m3_rid    = {2'd3, 4'd2};
    s3_rready = 3'b000;
    @(negedge aclk);
    chk("drop_rvalid", 64'(s3_rvalid), 64'd0);
    chk("drop_rready", 64'(m3_rready), 64'd1);
    cyc();
    m3_rid    = {2'd2, 4'd2};
    s3_rready = 3'b011;
    @(negedge aclk);
    chk("m2_rvalid", 64'(s3_rvalid), 64'b100);
    chk("m2_rready", 64'(m3_rready), 64'd0);
    cyc();
    m3_rvalid = 1'b0;

    // Reset while a request is held in SEND.
    do_reset();
    set_ar(1, 4'd6, 32'h5000, 8'd0);
    s_arvalid = 2'b10;
    m_arready = 1'b0;
    @(negedge aclk);
    chk("rs_grant", 64'(s_arready), 64'b10);
    cyc();
    set_ar(0, 4'd8, 32'h6000, 8'd0);
    s_arvalid = 2'b11;
    areset_n  = 1'b0;
    @(negedge aclk);
    chk("rs_send_before", 64'(m_arvalid), 64'd1);
    chk("rs_arready_forced", 64'(s_arready), 64'd0);
    cyc();
    areset_n = 1'b1;
    @(negedge aclk);
    chk("rs_arvalid_dropped", 64'(m_arvalid), 64'd0);
    chk("rs_master0_wins", 64'(s_arready), 64'b01);
    push({1'b0, 4'd8}, 32'h6000, 8'd0);
    m_arready = 1'b1;
    cyc();
    s_arvalid = '0;
    cyc();
    m_arready = 1'b0;

    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 20) begin
      cyc();
      wait_cnt++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL ar_drain: %0d requests never seen, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
